// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: four-phase I2C SCL / data-clock generator with slave clock-stretch
// detection (bounded by TIMEOUT), period/phase status and an idle mode.
// Latency: outputs decode registered state only; a phase lasts q_lat cycles plus held cycles.
// Backpressure: a slave holding SCL low in phase 2 freezes the quarter counter until
//   release or timeout; ena=0 returns to idle on the next edge.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ena              run enable (0 = idle)
//   div_q            quarter length in clk cycles, latched on activation and on period wrap
//   scl_not_ena      master not driving SCL; disables stretch detection
//   scl_in           synchronised sensed SCL level
//   scl_clk          SCL drive level
//   data_clk         high in phases 1 and 2
//   switch_range     high in phase 2
//   phase            current quarter 0..3
//   stretch          high the cycle after each held cycle
//   period_done      one-cycle pulse on the 3 -> 0 wrap
//   timeout_err      sticky stretch-timeout flag, cleared by rst or ena=0
module i2c_scl_gen #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 3500,
  parameter int TIMEOUT     = 65535,
  parameter int TO_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DIV_W-1:0] div_q,
  input  logic             scl_not_ena,
  input  logic             scl_in,
  output logic             scl_clk,
  output logic             data_clk,
  output logic             switch_range,
  output logic [1:0]       phase,
  output logic             stretch,
  output logic             period_done,
  output logic             timeout_err
);

  logic             active_q, active_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] qcnt_q, qcnt_d;
  logic [DIV_W-1:0] q_lat_q, q_lat_d;
  logic [TO_W-1:0]  scnt_q, scnt_d;
  logic             abandon_q, abandon_d;
  logic             stretch_q, stretch_d;
  logic             pdone_q, pdone_d;
  logic             terr_q, terr_d;
  logic             hold;
  logic [DIV_W-1:0] div_clamped;

  // Quarter lengths below 2 are forced to 2.
  assign div_clamped = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;

  // Slave holds SCL low while we release it in phase 2; ignored once abandoned.
  assign hold = active_q && (phase_q == 2'd2) && !scl_not_ena && !scl_in && !abandon_q;

  always_comb begin
    active_d  = active_q;
    phase_d   = phase_q;
    qcnt_d    = qcnt_q;
    q_lat_d   = q_lat_q;
    scnt_d    = scnt_q;
    abandon_d = abandon_q;
    stretch_d = hold;
    pdone_d   = 1'b0;
    terr_d    = terr_q;

    if (!ena) begin
      active_d  = 1'b0;
      phase_d   = 2'd0;
      qcnt_d    = '0;
      scnt_d    = '0;
      abandon_d = 1'b0;
      stretch_d = 1'b0;
      terr_d    = 1'b0;
    end else if (!active_q) begin
      active_d = 1'b1;
      q_lat_d  = div_clamped;
    end else if (hold) begin
      scnt_d = scnt_q + TO_W'(1);
      if (scnt_q == TO_W'(TIMEOUT - 1)) begin
        terr_d    = 1'b1;
        abandon_d = 1'b1;
      end
    end else if (qcnt_q == q_lat_q - DIV_W'(1)) begin
      qcnt_d    = '0;
      phase_d   = phase_q + 2'd1;
      scnt_d    = '0;
      abandon_d = 1'b0;
      if (phase_q == 2'd3) begin
        pdone_d = 1'b1;
        q_lat_d = div_clamped;
      end
    end else begin
      qcnt_d = qcnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      phase_q   <= 2'd0;
      qcnt_q    <= '0;
      q_lat_q   <= DIV_W'(DIV_DEFAULT);
      scnt_q    <= '0;
      abandon_q <= 1'b0;
      stretch_q <= 1'b0;
      pdone_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      phase_q   <= phase_d;
      qcnt_q    <= qcnt_d;
      q_lat_q   <= q_lat_d;
      scnt_q    <= scnt_d;
      abandon_q <= abandon_d;
      stretch_q <= stretch_d;
      pdone_q   <= pdone_d;
      terr_q    <= terr_d;
    end
  end

  // Idle drives SCL released (high) and data_clk low.
  assign scl_clk      = !active_q || phase_q[1];
  assign data_clk     = active_q && (phase_q[0] ^ phase_q[1]);
  assign switch_range = active_q && (phase_q == 2'd2);
  assign phase        = phase_q;
  assign stretch      = stretch_q;
  assign period_done  = pdone_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed bench for i2c_scl_gen with a queue of expected results.
// Two instances: default TIMEOUT for stretch tests, TIMEOUT=8 for the timeout test.
module tb_i2c_scl_gen;

  logic        clk, rst, ena, ena2;
  logic [15:0] div_q;
  logic        scl_not_ena, scl_in, scl_in2;
  logic        scl_clk, data_clk, switch_range, stretch, period_done, timeout_err;
  logic [1:0]  phase;
  logic        scl_clk2, data_clk2, switch_range2, stretch2, period_done2, timeout_err2;
  logic [1:0]  phase2;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  i2c_scl_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .div_q(div_q),
    .scl_not_ena(scl_not_ena), .scl_in(scl_in),
    .scl_clk(scl_clk), .data_clk(data_clk), .switch_range(switch_range),
    .phase(phase), .stretch(stretch), .period_done(period_done),
    .timeout_err(timeout_err)
  );

  i2c_scl_gen #(.TIMEOUT(8), .TO_W(4)) dut2 (
    .clk(clk), .rst(rst), .ena(ena2), .div_q(div_q),
    .scl_not_ena(1'b0), .scl_in(scl_in2),
    .scl_clk(scl_clk2), .data_clk(data_clk2), .switch_range(switch_range2),
    .phase(phase2), .stretch(stretch2), .period_done(period_done2),
    .timeout_err(timeout_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pops the next expected value from the scoreboard and compares.
  task automatic chk_pop(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // From activation: 16 cycles of phases 0..3 (div_q=4), then period_done.
  task automatic first_period(input string tag);
    int n;
    int p;
    int pd;
    n = 0;
    pd = 0;
    while (scl_clk !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, int'(n < 50), 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(i / 4);
    for (int i = 0; i < 16; i++) begin
      p = exp_q.pop_front();
      chk({tag, "_phase"}, int'(phase), p);
      chk({tag, "_scl"}, int'(scl_clk), int'(p >= 2));
      chk({tag, "_dclk"}, int'(data_clk), int'(p == 1 || p == 2));
      pd += int'(period_done);
      if (i < 15) @(negedge clk);
    end
    chk({tag, "_pd_early"}, pd, 0);
    @(negedge clk);
    chk({tag, "_pd_16"}, int'(period_done), 1);
  endtask

  // Measures one period, pulse to pulse. Optionally holds scl_in low for stl
  // cycles from phase 2 entry and writes new_div during phase 1.
  task automatic meas(input int stl, input int new_div,
                      output int per, output int sw, output int lo, output int st);
    int rem;
    bit started, low, div_set, done;
    per = 0; sw = 0; lo = 0; st = 0;
    rem = 0; started = 0; low = 0; div_set = 0; done = 0;
    while (!done && per < 200) begin
      @(negedge clk);
      per++;
      sw += int'(switch_range);
      lo += int'(!scl_clk);
      st += int'(stretch);
      if (period_done) done = 1;
      if (low) begin
        rem--;
        if (rem == 0) begin
          scl_in = 1'b1;
          low = 0;
        end
      end else if (stl > 0 && !started && switch_range) begin
        scl_in = 1'b0;
        started = 1;
        low = 1;
        rem = stl;
      end
      if (new_div >= 0 && !div_set && phase == 2'd1) begin
        div_q = 16'(new_div);
        div_set = 1;
      end
    end
    chk("meas_bound", int'(done), 1);
  endtask

  task automatic run_period(input string tag, input int stl, input int new_div,
                            input int e_per, input int e_sw, input int e_lo, input int e_st);
    int per, sw, lo, st;
    exp_q.push_back(e_per);
    exp_q.push_back(e_sw);
    exp_q.push_back(e_lo);
    exp_q.push_back(e_st);
    meas(stl, new_div, per, sw, lo, st);
    chk_pop({tag, "_period"}, per);
    chk_pop({tag, "_sw"}, sw);
    chk_pop({tag, "_scl_lo"}, lo);
    chk_pop({tag, "_stretch"}, st);
  endtask

  task automatic meas2(output int per, output int sw);
    bit done;
    per = 0; sw = 0; done = 0;
    while (!done && per < 200) begin
      @(negedge clk);
      per++;
      sw += int'(switch_range2);
      if (period_done2) done = 1;
    end
    chk("meas2_bound", int'(done), 1);
  endtask

  task automatic wait_sw(input string tag);
    int n;
    n = 0;
    while (switch_range !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sw_seen"}, int'(n < 100), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_scl"}, int'(scl_clk), 1);
    chk({tag, "_dclk"}, int'(data_clk), 0);
    chk({tag, "_sw"}, int'(switch_range), 0);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_stretch"}, int'(stretch), 0);
    chk({tag, "_pd"}, int'(period_done), 0);
    chk({tag, "_terr"}, int'(timeout_err), 0);
  endtask

  initial begin
    int per, sw;
    int n;
    rst = 1'b1; ena = 1'b0; ena2 = 1'b0; div_q = 16'd4;
    scl_not_ena = 1'b0; scl_in = 1'b1; scl_in2 = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    // Release: first period, then steady periods.
    rst = 1'b0; ena = 1'b1; ena2 = 1'b1;
    first_period("start");
    run_period("norm1", 0, -1, 16, 4, 8, 0);
    run_period("norm2", 0, -1, 16, 4, 8, 0);

    // 10-cycle stretch from phase 2 entry.
    run_period("str10", 10, -1, 26, 14, 8, 10);
    chk("str10_terr", int'(timeout_err), 0);
    run_period("after_str", 0, -1, 16, 4, 8, 0);

    // div_q changes only take effect at the wrap; 0 clamps to 2.
    run_period("div4to6", 0, 6, 16, 4, 8, 0);
    run_period("div6", 0, 0, 24, 6, 12, 0);
    run_period("div0", 0, 4, 8, 2, 4, 0);
    run_period("div4", 0, -1, 16, 4, 8, 0);

    // scl_in low ignored while the master is not driving SCL.
    scl_not_ena = 1'b1; scl_in = 1'b0;
    run_period("notena", 0, -1, 16, 4, 8, 0);
    scl_not_ena = 1'b0; scl_in = 1'b1;

    // TIMEOUT=8 instance with SCL stuck low.
    n = 0;
    while (period_done2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_sync", int'(n < 100), 1);
    exp_q.push_back(24); exp_q.push_back(12);
    meas2(per, sw);
    chk_pop("to_period1", per);
    chk_pop("to_sw1", sw);
    chk("to_terr1", int'(timeout_err2), 1);
    exp_q.push_back(24); exp_q.push_back(12);
    meas2(per, sw);
    chk_pop("to_period2", per);
    chk_pop("to_sw2", sw);
    chk("to_terr2", int'(timeout_err2), 1);
    ena2 = 1'b0;
    @(negedge clk);
    chk("to_idle_terr", int'(timeout_err2), 0);
    chk("to_idle_scl", int'(scl_clk2), 1);

    // Reset during a phase 2 stretch.
    wait_sw("rst");
    scl_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stretching", int'(stretch), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid");
    rst = 1'b0; scl_in = 1'b1;
    first_period("rst_rel");

    // ena dropped during a phase 2 stretch.
    wait_sw("ena");
    scl_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_stretching", int'(stretch), 1);
    ena = 1'b0;
    @(negedge clk);
    chk_idle("ena_mid");
    ena = 1'b1; scl_in = 1'b1;
    first_period("ena_rel");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
- Parametrised next-generation I2C bit-clock generator for the I2C master.
- Divides clk into a four-phase SCL period with a runtime-programmable quarter length.
- Provides slave clock-stretch detection with a bounded timeout, period/phase status and an idle mode.
- Drives the bit-level shifter (data_clk edges) and the SCL pad driver (scl_clk).

Parameters:
- DIV_W, 16, width of div_q and the quarter counter.
- DIV_DEFAULT, 3500, quarter length loaded at reset, in clk cycles.
- TIMEOUT, 65535, maximum consecutive stretch-hold cycles in one phase 2 before abandoning the stretch.
- TO_W, 16, width of the stretch counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  run enable; 0 puts the generator in idle.
- div_q  in  DIV_W  quarter length in cycles; latched only at period boundaries.
- scl_not_ena  in  1  1 = master not driving SCL; stretch detection disabled.
- scl_in  in  1  synchronised sensed SCL line level.
- scl_clk  out  1  SCL drive level.
- data_clk  out  1  data clock, high in phases 1 and 2.
- switch_range  out  1  high while phase==2.
- phase  out  2  current quarter, 0..3.
- stretch  out  1  registered; high the cycle after each held cycle.
- period_done  out  1  one-cycle pulse on the phase 3 -> 0 wrap.
- timeout_err  out  1  sticky stretch-timeout flag.

Behaviour:
- State registers: active, phase, qcnt (DIV_W bits), q_lat (DIV_W bits), scnt (TO_W bits), abandon. All outputs decode registered state only; no combinational path from inputs to outputs.
- Reset:
  - active=0, phase=0, qcnt=0, q_lat=DIV_DEFAULT, scnt=0, abandon=0.
  - Outputs: scl_clk=1, data_clk=0, switch_range=0, stretch=0, period_done=0, timeout_err=0.
  - rst takes priority over all other events.
- Idle (ena=0 sampled):
  - Next cycle: active=0, phase=0, qcnt=0, scnt=0, abandon=0, stretch=0, timeout_err=0.
  - Idle outputs: scl_clk=1, data_clk=0, switch_range=0, period_done=0.
  - A high ena sample sets active=1. q_lat is loaded with max(div_q,2) on that same edge.
- Phase decode when active:
  - phase 0: scl_clk=0, data_clk=0.
  - phase 1: scl_clk=0, data_clk=1.
  - phase 2: scl_clk=1, data_clk=1.
  - phase 3: scl_clk=1, data_clk=0.
- hold: active && phase==2 && scl_not_ena==0 && scl_in==0 && !abandon.
  - Evaluated every cycle from the current input samples.
  - stretch <= hold.
- Advance when active && !hold:
  - If qcnt == q_lat-1: qcnt<=0, phase<=phase+1 (mod 4), scnt<=0, abandon<=0.
  - On the 3->0 wrap additionally: period_done<=1 and q_lat<=max(div_q,2).
  - Otherwise qcnt<=qcnt+1.
  - period_done is 0 on every other cycle.
- Hold cycle:
  - qcnt and phase frozen; scnt<=scnt+1.
  - If scnt == TIMEOUT-1: timeout_err<=1 and abandon<=1. The phase then resumes counting with scl_in ignored until phase leaves 2.
- Latency:
  - Phase changes on the edge after the cycle where qcnt==q_lat-1, so each phase lasts q_lat cycles plus held cycles.
  - Unstretched period = 4*q_lat.
- Boundaries:
  - div_q of 0 or 1 is clamped to 2.
  - A div_q change mid-period has no effect until the next wrap.
  - scl_in low outside phase 2, or with scl_not_ena=1, is ignored.
  - A stretch beginning on the last count of phase 2 still holds.
  - ena deassert mid-stretch aborts immediately: idle next cycle, timeout_err cleared.
  - timeout_err clears only on rst or ena=0.

Test Plan:
- div_q=4, ena=1, scl_in=1: phases of 4 cycles each (0,1,2,3); period_done every 16 cycles; switch_range high 4 cycles per period; scl_clk low 8 / high 8.
- div_q=4, scl_in held low 10 cycles starting at phase 2 entry: stretch high 10 cycles (delayed one cycle); phase 2 lasts 14 cycles; period 26; timeout_err stays 0.
- TIMEOUT=8, div_q=4, scl_in stuck low: 8 held cycles, timeout_err=1 and abandon; phase 2 totals 12 cycles; next period's phase 2 also 12 cycles; timeout_err stays 1 until ena=0.
- div_q 4->6 written in phase 1: current period 16 cycles, next 24. Then div_q=0: next period 8 cycles (clamp 2).
- scl_not_ena=1, scl_in=0 throughout, div_q=4: no stretch; period 16.
- rst asserted (then separately ena dropped) during a phase 2 stretch: next cycle scl_clk=1, data_clk=0, phase=0, stretch=0, timeout_err=0. After release with ena=1, the first period_done comes 16 cycles later (div_q=4).
